// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and constants for the SS.cc stopwatch.
// FSM encoding, BCD limits, digit nibble ranges, default timing.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] BCD_MAX_DEC = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

    localparam int NIB_ST_HI = 15;
    localparam int NIB_ST_LO = 12;
    localparam int NIB_SU_HI = 11;
    localparam int NIB_SU_LO = 8;
    localparam int NIB_CT_HI = 7;
    localparam int NIB_CT_LO = 4;
    localparam int NIB_CU_HI = 3;
    localparam int NIB_CU_LO = 0;

    localparam int TICK_DIV_DEF = 200;
    localparam int DEBOUNCE_DEF = 100;

    // Returns {carry_out, next_digit} for one cascade stage.
    function automatic logic [4:0] bcd_step(
        input logic [3:0] d,
        input logic [3:0] lim,
        input logic       en
    );
        if (!en) begin
            return {1'b0, d};
        end
        if (d == lim) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Button inputs and display/status outputs of the stopwatch.
// master drives buttons, slave is the stopwatch itself.
interface stopwatch_bcd_counter_if;

    logic        xStartStop;
    logic        xClear;
    logic [15:0] xDOutput;
    logic        xRunning;
    logic        xOverflow;

    modport master (
        output xStartStop,
        output xClear,
        input  xDOutput,
        input  xRunning,
        input  xOverflow
    );

    modport slave (
        input  xStartStop,
        input  xClear,
        output xDOutput,
        output xRunning,
        output xOverflow
    );

endinterface

// File: rtl/stopwatch_bcd_counter_button_debounce.sv
// Raw button to one-cycle press pulse: 2-FF sync, debounce, edge detect.
// Releases are debounced too but never pulse.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int dDebounce = DEBOUNCE_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(dDebounce + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count while the synced sample disagrees; flip when the count hits dDebounce.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(dDebounce - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and registered rising-edge pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Four-digit BCD stopwatch SS.cc with start/stop and clear buttons.
// Digit registers feed the display word directly.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int dTickDiv  = TICK_DIV_DEF,
    parameter int dDebounce = DEBOUNCE_DEF
) (
    input  logic xClk_20kHz,
    input  logic xRst_n,
    stopwatch_bcd_counter_if.slave sw
);

    localparam int PW = $clog2(dTickDiv);

    sw_state_e     state_q;
    sw_state_e     state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [3:0]    st_q, su_q, ct_q, cu_q;
    logic [3:0]    st_d, su_d, ct_d, cu_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          ss_p;
    logic          clr_p;
    logic          tick;
    logic          running;
    logic [4:0]    s0, s1, s2, s3;

    button_debounce #(.dDebounce(dDebounce)) u_db_ss (
        .clk_i   (xClk_20kHz),
        .rst_n_i (xRst_n),
        .btn_i   (sw.xStartStop),
        .press_o (ss_p)
    );

    button_debounce #(.dDebounce(dDebounce)) u_db_clr (
        .clk_i   (xClk_20kHz),
        .rst_n_i (xRst_n),
        .btn_i   (sw.xClear),
        .press_o (clr_p)
    );

    // FSM state register.
    always_ff @(posedge xClk_20kHz) begin
        if (!xRst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear overrides start/stop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_p) state_d = RUN;
            RUN:     if (ss_p) state_d = PAUSE;
            PAUSE:   if (ss_p) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (clr_p) begin
            state_d = IDLE;
        end
    end

    // FSM outputs.
    always_comb begin
        running = (state_q == RUN);
    end

    // Prescaler, tick and BCD cascade next state.
    always_comb begin
        tick    = running && (presc_q == PW'(dTickDiv - 1));
        presc_d = presc_q;
        if (clr_p || state_q == IDLE) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        s0    = bcd_step(cu_q, BCD_MAX_DEC, tick);
        s1    = bcd_step(ct_q, BCD_MAX_DEC, s0[4]);
        s2    = bcd_step(su_q, BCD_MAX_DEC, s1[4]);
        s3    = bcd_step(st_q, BCD_MAX_SEC_TENS, s2[4]);
        cu_d  = s0[3:0];
        ct_d  = s1[3:0];
        su_d  = s2[3:0];
        st_d  = s3[3:0];
        ovf_d = s3[4];
        if (clr_p) begin
            cu_d  = 4'd0;
            ct_d  = 4'd0;
            su_d  = 4'd0;
            st_d  = 4'd0;
            ovf_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge xClk_20kHz) begin
        if (!xRst_n) begin
            presc_q <= '0;
            st_q    <= 4'd0;
            su_q    <= 4'd0;
            ct_q    <= 4'd0;
            cu_q    <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            st_q    <= st_d;
            su_q    <= su_d;
            ct_q    <= ct_d;
            cu_q    <= cu_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sw.xDOutput[NIB_ST_HI:NIB_ST_LO] = st_q;
    assign sw.xDOutput[NIB_SU_HI:NIB_SU_LO] = su_q;
    assign sw.xDOutput[NIB_CT_HI:NIB_CT_LO] = ct_q;
    assign sw.xDOutput[NIB_CU_HI:NIB_CU_LO] = cu_q;
    assign sw.xRunning  = running;
    assign sw.xOverflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter (tick divider shortened to 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_bcd_counter;

    localparam int TD = 4;
    localparam int DB = 100;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    stopwatch_bcd_counter_if sw_if ();

    stopwatch_bcd_counter #(
        .dTickDiv  (TD),
        .dDebounce (DB)
    ) dut (
        .xClk_20kHz (clk),
        .xRst_n     (rst_n),
        .sw         (sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise start/stop, return on the edge the FSM reacts, then release.
    task automatic press_ss();
        sw_if.xStartStop = 1'b1;
        wait_n(DB + 4);
        sw_if.xStartStop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw_if.xStartStop = i[0];
            sw_if.xClear = ~i[0];
            wait_n(1);
        end
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_dout: got %h want 0000", sw_if.xDOutput);
        end
        n_checks++;
        if (sw_if.xRunning !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_running: got %b want 0", sw_if.xRunning);
        end
        n_checks++;
        if (sw_if.xOverflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ovf: got %b want 0", sw_if.xOverflow);
        end
        sw_if.xStartStop = 1'b0;
        sw_if.xClear = 1'b0;
        rst_n = 1'b1;
        wait_n(300);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000 || sw_if.xRunning !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: dout %h run %b want 0000 0",
                     sw_if.xDOutput, sw_if.xRunning);
        end
    endtask

    task automatic test_debounce();
        sw_if.xStartStop = 1'b1;
        wait_n(60);
        sw_if.xStartStop = 1'b0;
        wait_n(300);
        n_checks++;
        if (sw_if.xRunning !== 1'b0 || sw_if.xDOutput !== 16'h0000) begin
            n_errors++;
            $display("FAIL glitch: run %b dout %h want 0 0000",
                     sw_if.xRunning, sw_if.xDOutput);
        end
        sw_if.xStartStop = 1'b1;
        wait_n(DB + 3);
        n_checks++;
        if (sw_if.xRunning !== 1'b0) begin
            n_errors++;
            $display("FAIL press_early: run %b want 0", sw_if.xRunning);
        end
        wait_n(1);
        n_checks++;
        if (sw_if.xRunning !== 1'b1) begin
            n_errors++;
            $display("FAIL press_latency: run %b want 1", sw_if.xRunning);
        end
        wait_n(46);
        sw_if.xStartStop = 1'b0;
    endtask

    task automatic test_count_pause();
        wait_n(TD * 1234 - 1 - 46);
        n_checks++;
        if (sw_if.xDOutput !== 16'h1233) begin
            n_errors++;
            $display("FAIL count_1233: got %h want 1233", sw_if.xDOutput);
        end
        wait_n(1);
        n_checks++;
        if (sw_if.xDOutput !== 16'h1234) begin
            n_errors++;
            $display("FAIL count_1234: got %h want 1234", sw_if.xDOutput);
        end
        wait_n(1);
        sw_if.xStartStop = 1'b1;
        wait_n(DB + 3);
        n_checks++;
        if (sw_if.xRunning !== 1'b1) begin
            n_errors++;
            $display("FAIL pause_early: run %b want 1", sw_if.xRunning);
        end
        wait_n(1);
        sw_if.xStartStop = 1'b0;
        n_checks++;
        if (sw_if.xRunning !== 1'b0 || sw_if.xDOutput !== 16'h1260) begin
            n_errors++;
            $display("FAIL pause_enter: run %b dout %h want 0 1260",
                     sw_if.xRunning, sw_if.xDOutput);
        end
        wait_n(5000);
        n_checks++;
        if (sw_if.xDOutput !== 16'h1260) begin
            n_errors++;
            $display("FAIL pause_hold: got %h want 1260", sw_if.xDOutput);
        end
        press_ss();
        n_checks++;
        if (sw_if.xRunning !== 1'b1) begin
            n_errors++;
            $display("FAIL resume: run %b want 1", sw_if.xRunning);
        end
        wait_n(2);
        n_checks++;
        if (sw_if.xDOutput !== 16'h1260) begin
            n_errors++;
            $display("FAIL resume_early: got %h want 1260", sw_if.xDOutput);
        end
        wait_n(1);
        n_checks++;
        if (sw_if.xDOutput !== 16'h1261) begin
            n_errors++;
            $display("FAIL resume_tick: got %h want 1261", sw_if.xDOutput);
        end
    endtask

    task automatic test_wrap();
        wait_n(TD * 4738);
        n_checks++;
        if (sw_if.xDOutput !== 16'h5999 || sw_if.xOverflow !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_5999: dout %h ovf %b want 5999 0",
                     sw_if.xDOutput, sw_if.xOverflow);
        end
        wait_n(TD);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000 || sw_if.xOverflow !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_0000: dout %h ovf %b want 0000 1",
                     sw_if.xDOutput, sw_if.xOverflow);
        end
        n_checks++;
        if (sw_if.xRunning !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_run: run %b want 1", sw_if.xRunning);
        end
        wait_n(1);
        n_checks++;
        if (sw_if.xOverflow !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_pulse: ovf %b want 0", sw_if.xOverflow);
        end
    endtask

    task automatic test_clear_priority();
        wait_n(65);
        sw_if.xStartStop = 1'b1;
        sw_if.xClear = 1'b1;
        wait_n(102);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0042 || sw_if.xRunning !== 1'b1) begin
            n_errors++;
            $display("FAIL both_pre: dout %h run %b want 0042 1",
                     sw_if.xDOutput, sw_if.xRunning);
        end
        wait_n(2);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000 || sw_if.xRunning !== 1'b0) begin
            n_errors++;
            $display("FAIL both_clear: dout %h run %b want 0000 0",
                     sw_if.xDOutput, sw_if.xRunning);
        end
        sw_if.xStartStop = 1'b0;
        sw_if.xClear = 1'b0;
        wait_n(300);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000 || sw_if.xRunning !== 1'b0) begin
            n_errors++;
            $display("FAIL both_idle: dout %h run %b want 0000 0",
                     sw_if.xDOutput, sw_if.xRunning);
        end
    endtask

    task automatic test_clear_on_tick();
        press_ss();
        wait_n(96);
        sw_if.xClear = 1'b1;
        wait_n(DB + 3);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0049 || sw_if.xRunning !== 1'b1) begin
            n_errors++;
            $display("FAIL tickclr_pre: dout %h run %b want 0049 1",
                     sw_if.xDOutput, sw_if.xRunning);
        end
        wait_n(1);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000 || sw_if.xOverflow !== 1'b0
            || sw_if.xRunning !== 1'b0) begin
            n_errors++;
            $display("FAIL tickclr: dout %h ovf %b run %b want 0000 0 0",
                     sw_if.xDOutput, sw_if.xOverflow, sw_if.xRunning);
        end
        sw_if.xClear = 1'b0;
        wait_n(300);
    endtask

    task automatic test_reset_midrun();
        press_ss();
        wait_n(TD * 3017);
        n_checks++;
        if (sw_if.xDOutput !== 16'h3017) begin
            n_errors++;
            $display("FAIL midrun_3017: got %h want 3017", sw_if.xDOutput);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw_if.xStartStop = ~i[0];
            sw_if.xClear = i[0];
            wait_n(1);
        end
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000 || sw_if.xRunning !== 1'b0
            || sw_if.xOverflow !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_rst: dout %h run %b ovf %b want 0000 0 0",
                     sw_if.xDOutput, sw_if.xRunning, sw_if.xOverflow);
        end
        sw_if.xStartStop = 1'b0;
        sw_if.xClear = 1'b0;
        rst_n = 1'b1;
        wait_n(300);
        press_ss();
        n_checks++;
        if (sw_if.xRunning !== 1'b1 || sw_if.xDOutput !== 16'h0000) begin
            n_errors++;
            $display("FAIL restart: run %b dout %h want 1 0000",
                     sw_if.xRunning, sw_if.xDOutput);
        end
        wait_n(TD - 1);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0000) begin
            n_errors++;
            $display("FAIL restart_early: got %h want 0000", sw_if.xDOutput);
        end
        wait_n(1);
        n_checks++;
        if (sw_if.xDOutput !== 16'h0001) begin
            n_errors++;
            $display("FAIL restart_tick: got %h want 0001", sw_if.xDOutput);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        sw_if.xStartStop = 1'b0;
        sw_if.xClear = 1'b0;
        wait_n(1);
        test_reset();
        test_debounce();
        test_count_pause();
        test_wrap();
        test_clear_priority();
        test_clear_on_tick();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
